pwm_channel_bank: RTL and testbench

Multi-channel PWM generator that sits directly upstream of the `tt_um_devinatkin_pwm` top-level pin mapping. It holds per-channel duty values in double-buffered registers loaded through a simple write port, runs a shared period counter, and drives one registered PWM bit per channel plus a period-start pulse. The top level instantiates it with its active-low pin reset inverted into `rst`, and routes `pwm_out` and `period_start` onto `uo_out`.

---
 rtl/pwm_channel_bank.sv | 110 +++++++++++
 tb/tb_pwm_channel_bank.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_channel_bank.sv
// pwm_channel_bank: multi-channel PWM generator with a shared period counter.
// Each channel has a shadow duty register (written through a simple write
// port) and an active duty register that is refreshed only when the period
// counter wraps. Optional prescaler is built when PWM_PRESCALE_EN is defined;
// without it the counter advances every clock.
//
// Write port handshake: there is no backpressure. A write is accepted on
// every rising edge where wr_en=1. wr_addr 0..CHANNELS-1 selects a duty
// shadow register, 7 selects the prescale shadow register, and every other
// address is dropped.
module pwm_channel_bank #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [2:0]          wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start
);

  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    duty_shadow_q [CHANNELS];
  logic [WIDTH-1:0]    duty_active_q [CHANNELS];
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                period_start_q;
  logic                tick;
  logic                load;

`ifdef PWM_PRESCALE_EN
  logic [WIDTH-1:0] pre_cnt_q, pre_cnt_d;
  logic [WIDTH-1:0] prescale_shadow_q;
  logic [WIDTH-1:0] prescale_active_q;

  // Tick when the prescale count reaches the active prescale value.
  always_comb begin
    tick      = (pre_cnt_q == prescale_active_q);
    pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
  end

  // Prescale counter plus its shadow/active pair; active changes only on load.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q         <= '0;
      prescale_shadow_q <= '0;
      prescale_active_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      if (wr_en && (wr_addr == 3'd7)) begin
        prescale_shadow_q <= wr_data;
      end
      if (load) begin
        prescale_active_q <= prescale_shadow_q;
      end
    end
  end
`else
  // No prescaler: the period counter advances on every clock.
  assign tick = 1'b1;
`endif

  // Next counter value, load detection (wrap from max) and per-channel compare.
  always_comb begin
    load  = tick && (cnt_q == '1);
    cnt_d = tick ? cnt_q + 1'b1 : cnt_q;
    pwm_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = (cnt_q < duty_active_q[i]);
    end
  end

  // Duty registers: writes land in the shadow; a load copies the pre-edge
  // shadow into the active register, so a write on the load edge waits a period.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        duty_shadow_q[i] <= '0;
        duty_active_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_en && (wr_addr == 3'(i))) begin
          duty_shadow_q[i] <= wr_data;
        end
        if (load) begin
          duty_active_q[i] <= duty_shadow_q[i];
        end
      end
    end
  end

  // Period counter, registered PWM outputs and the period-start pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      pwm_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      pwm_q          <= pwm_d;
      period_start_q <= load;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_channel_bank.sv
// Bench for pwm_channel_bank: table of reset/write vectors, hand-written
// sequences for duty extremes, shadow timing, prescaler and mid-period reset,
// then random traffic checked every cycle against a period/phase model.
module tb_pwm_channel_bank;
  localparam int CH = 4;
  localparam int W  = 8;
  localparam int PERIOD_TICKS = 1 << W;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [2:0]    wr_addr;
  logic [W-1:0]  wr_data;
  logic [CH-1:0] pwm_out;
  logic          period_start;

  int n_vec;
  int n_err;

  // Reference model state: clocks elapsed in the current period, duty values
  // and prescale in effect, and what the outputs must show after each edge.
  int m_phase;
  int m_sh [CH];
  int m_act [CH];
  int m_pre;
  int m_pre_sh;
  int exp_pwm;
  int exp_ps;

  typedef struct {
    logic          rst;
    logic          wr_en;
    logic [2:0]    addr;
    logic [W-1:0]  data;
    logic [CH-1:0] exp_pwm;
    logic          exp_ps;
  } vec_t;

  vec_t tbl [8];

  pwm_channel_bank #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model update for one rising edge, using the inputs presented to that edge.
  task automatic model_edge();
    int tick_len;
    int e;
    if (rst) begin
      m_phase = 0; m_pre = 0; m_pre_sh = 0; exp_pwm = 0; exp_ps = 0;
      for (int i = 0; i < CH; i++) begin
        m_sh[i] = 0; m_act[i] = 0;
      end
    end else begin
      tick_len = m_pre + 1;
      e = 0;
      for (int i = 0; i < CH; i++) begin
        if ((m_phase / tick_len) < m_act[i]) e = e | (1 << i);
      end
      exp_pwm = e;
      exp_ps  = 0;
      m_phase = m_phase + 1;
      if (m_phase == PERIOD_TICKS * tick_len) begin
        m_phase = 0;
        exp_ps  = 1;
        m_pre   = m_pre_sh;
        for (int i = 0; i < CH; i++) m_act[i] = m_sh[i];
      end
      if (wr_en) begin
        if (int'(wr_addr) < CH) m_sh[wr_addr] = int'(wr_data);
`ifdef PWM_PRESCALE_EN
        if (wr_addr == 3'd7) m_pre_sh = int'(wr_data);
`endif
      end
    end
  endtask

  // One clock: update the model at the edge, compare just after it.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("pwm_out", 32'(pwm_out), 32'(exp_pwm));
    chk("period_start", 32'(period_start), 32'(exp_ps));
  endtask

  task automatic write1(input logic [2:0] a, input logic [W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // Step until period_start is seen or the bound expires; returns edges taken.
  task automatic wait_ps(input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!period_start && n < limit);
  endtask

  initial begin
    int n;
    int h0, h1, h2;
    n_vec = 0; n_err = 0;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    m_phase = 0; m_pre = 0; m_pre_sh = 0; exp_pwm = 0; exp_ps = 0;
    for (int i = 0; i < CH; i++) begin m_sh[i] = 0; m_act[i] = 0; end

    // Reset held 5 clocks with wr_en toggling, then three duty writes.
    tbl[0] = '{1'b1, 1'b1, 3'd0, 8'd99,  4'b0000, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 3'd1, 8'd11,  4'b0000, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 3'd2, 8'd22,  4'b0000, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 3'd7, 8'd3,   4'b0000, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 3'd3, 8'd200, 4'b0000, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 3'd0, 8'd64,  4'b0000, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 3'd1, 8'd0,   4'b0000, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 3'd2, 8'd255, 4'b0000, 1'b0};
    for (int i = 0; i < 8; i++) begin
      rst = tbl[i].rst; wr_en = tbl[i].wr_en;
      wr_addr = tbl[i].addr; wr_data = tbl[i].data;
      step();
      chk("tbl_pwm", 32'(pwm_out), 32'(tbl[i].exp_pwm));
      chk("tbl_ps", 32'(period_start), 32'(tbl[i].exp_ps));
    end
    rst = 1'b0; wr_en = 1'b0;

    // First period_start 256 clocks after the last reset edge.
    wait_ps(400, n);
    chk("first_ps_delay", 32'(n + 3), 32'd256);

    // Duties 64 / 0 / 255 over one full period.
    h0 = 0; h1 = 0; h2 = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      h0 += int'(pwm_out[0]); h1 += int'(pwm_out[1]); h2 += int'(pwm_out[2]);
    end
    chk("ch0_high_64", 32'(h0), 32'd64);
    chk("ch1_high_0", 32'(h1), 32'd0);
    chk("ch2_high_255", 32'(h2), 32'd255);
    chk("ps_spacing_256", 32'(period_start), 32'd1);

    // Mid-period write of 128 at cnt=100: this period keeps 64.
    h0 = 0;
    for (int k = 0; k < 256; k++) begin
      wr_en = (k == 100); wr_addr = 3'd0; wr_data = 8'd128;
      step();
      h0 += int'(pwm_out[0]);
    end
    wr_en = 1'b0;
    chk("shadow_keep_64", 32'(h0), 32'd64);

    // Next period shows 128; write 32 on the load edge at its end.
    h0 = 0;
    for (int k = 0; k < 256; k++) begin
      wr_en = (k == 255); wr_addr = 3'd0; wr_data = 8'd32;
      step();
      h0 += int'(pwm_out[0]);
    end
    wr_en = 1'b0;
    chk("shadow_new_128", 32'(h0), 32'd128);
    chk("load_edge_ps", 32'(period_start), 32'd1);
    h0 = 0;
    for (int k = 0; k < 256; k++) begin step(); h0 += int'(pwm_out[0]); end
    chk("load_edge_write_deferred", 32'(h0), 32'd128);
    h0 = 0;
    for (int k = 0; k < 256; k++) begin step(); h0 += int'(pwm_out[0]); end
    chk("load_edge_write_applied", 32'(h0), 32'd32);

    // Prescale 3 with ch0=64.
    write1(3'd7, 8'd3);
    write1(3'd0, 8'd64);
    wait_ps(2000, n);
    chk("pre_load_seen", 32'(period_start), 32'd1);
    n = 0; h0 = 0;
    do begin
      step(); n++; h0 += int'(pwm_out[0]);
    end while (!period_start && n < 2000);
`ifdef PWM_PRESCALE_EN
    chk("pre_spacing", 32'(n), 32'd1024);
    chk("pre_high", 32'(h0), 32'd256);
`else
    chk("pre_spacing", 32'(n), 32'd256);
    chk("pre_high", 32'(h0), 32'd64);
`endif

    // Back to prescale 0, then load ch0=200 and reset near cnt=100.
    write1(3'd7, 8'd0);
    wait_ps(2000, n);
    write1(3'd0, 8'd200);
    wait_ps(2000, n);
    chk("dut200_load_seen", 32'(period_start), 32'd1);
    for (int k = 0; k < 100; k++) step();
    chk("pre_rst_high", 32'(pwm_out[0]), 32'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_pwm", 32'(pwm_out), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 300; k++) begin
      step();
      chk("post_rst_pwm", 32'(pwm_out), 32'd0);
    end

    // Random traffic against the model.
    for (int k = 0; k < 20000; k++) begin
      rst     = ($urandom_range(0, 2999) == 0);
      wr_en   = ($urandom_range(0, 15) == 0);
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = (wr_addr == 3'd7) ? W'($urandom_range(0, 3)) : W'($urandom_range(0, 255));
      step();
    end
    rst = 1'b0; wr_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
